// File: rtl/lot_sense.sv
// Input conditioning for the rush-hour controller: synchronizes and debounces
// the per-space occupancy sensors and turns the hour key into an hour counter.
module lot_sense #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] sensor,
  input  logic       hour_key,
  output logic [2:0] pp,
  output logic [2:0] hour,
  output logic [1:0] free_cnt,
  output logic       arrive,
  output logic       depart,
  output logic       day_end
);

  localparam int unsigned N_SPACES = 3;
  localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SPACES-1:0]            sens_s1;
  logic [N_SPACES-1:0]            sens_s2;
  logic                           key_s1;
  logic                           key_s2;
  logic                           key_prev;
  logic                           key_rise;
  logic [N_SPACES-1:0][CNT_W-1:0] cnt;
  logic [N_SPACES-1:0][CNT_W-1:0] cnt_next;
  logic [N_SPACES-1:0]            pp_next;

  // Two-flop synchronizers; key flops reset high so a key held through reset is not a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sens_s1  <= '0;
      sens_s2  <= '0;
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_prev <= 1'b1;
    end else begin
      sens_s1  <= sensor;
      sens_s2  <= sens_s1;
      key_s1   <= hour_key;
      key_s2   <= key_s1;
      key_prev <= key_s2;
    end
  end

  assign key_rise = key_s2 & ~key_prev;

  // Per-space debounce: a disagreement must persist DEBOUNCE_CYCLES cycles to flip pp.
  always_comb begin
    pp_next  = pp;
    cnt_next = '0;
    for (int unsigned i = 0; i < N_SPACES; i++) begin
      if (sens_s2[i] != pp[i]) begin
        if (cnt[i] == CNT_MAX) begin
          pp_next[i] = sens_s2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pp     <= '0;
      cnt    <= '0;
      arrive <= 1'b0;
      depart <= 1'b0;
    end else begin
      pp     <= pp_next;
      cnt    <= cnt_next;
      arrive <= |(pp_next & ~pp);
      depart <= |(~pp_next & pp);
    end
  end

  // Hour counter wraps 7 -> 0 and flags the end of the day on that edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hour    <= '0;
      day_end <= 1'b0;
    end else begin
      day_end <= key_rise && (hour == 3'd7);
      if (key_rise) begin
        hour <= hour + 3'd1;
      end
    end
  end

  always_comb begin
    free_cnt = {1'b0, ~pp[0]} + {1'b0, ~pp[1]} + {1'b0, ~pp[2]};
  end

endmodule
